// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter with a one-word registered output stage.
// Strict alternation when both channels request; back-pressure freezes priority.
module rr_arb2 #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             out_src,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state_r, state_nxt_s;
  logic               prio_r;
  logic [WIDTH-1:0]   out_data_r;
  logic               out_src_r;
  logic [CNT_W-1:0]   cnt_a_r, cnt_b_r;
  logic               load_s, grant_any_s, grant_b_s, transfer_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  // Grant decision: a lone requester wins, a tie goes to the prio channel.
  always_comb begin
    grant_any_s = 1'b0;
    grant_b_s   = prio_r;
    case ({a_valid, b_valid})
      2'b10: begin grant_any_s = 1'b1; grant_b_s = 1'b0;   end
      2'b01: begin grant_any_s = 1'b1; grant_b_s = 1'b1;   end
      2'b11: begin grant_any_s = 1'b1; grant_b_s = prio_r; end
      default: begin grant_any_s = 1'b0; grant_b_s = prio_r; end
    endcase
  end

  assign load_s     = (state_r == EMPTY) || out_ready;
  assign transfer_s = load_s && grant_any_s;

  // Handshake outputs; forced low while reset is asserted.
  always_comb begin
    sel     = 1'b0;
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (rst) begin
      sel     = 1'b0;
      a_ready = 1'b0;
      b_ready = 1'b0;
    end else begin
      sel     = grant_b_s;
      a_ready = transfer_s && !grant_b_s;
      b_ready = transfer_s && grant_b_s;
    end
  end

  // Output-stage next state: a load either refills or empties the register.
  always_comb begin
    state_nxt_s = state_r;
    if (load_s) begin
      if (grant_any_s) begin
        state_nxt_s = FULL;
      end else begin
        state_nxt_s = EMPTY;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output-stage state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath, priority pointer and grant counters update only on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r <= {WIDTH{1'b0}};
      out_src_r  <= 1'b0;
      prio_r     <= 1'b0;
      cnt_a_r    <= {CNT_W{1'b0}};
      cnt_b_r    <= {CNT_W{1'b0}};
    end else if (transfer_s) begin
      out_data_r <= grant_b_s ? b_data : a_data;
      out_src_r  <= grant_b_s;
      prio_r     <= !grant_b_s;
      if (grant_b_s) begin
        cnt_b_r <= sat_inc(cnt_b_r);
      end else begin
        cnt_a_r <= sat_inc(cnt_a_r);
      end
    end
  end

  assign out_valid = (state_r == FULL);
  assign out_data  = out_data_r;
  assign out_src   = out_src_r;
  assign cnt_a     = cnt_a_r;
  assign cnt_b     = cnt_b_r;

endmodule

// File: tb/tb_rr_arb2.sv
// Self-checking bench for rr_arb2: reference model feeds a scoreboard queue
// on acceptance; entries are compared as the DUT presents output words.
module tb_rr_arb2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  a_data = 8'h00, b_data = 8'h00;
  logic        a_ready, b_ready, sel, out_valid, out_src;
  logic [7:0]  out_data;
  logic [15:0] cnt_a, cnt_b;

  // Second instance with narrow counters for saturation.
  logic        s_valid = 1'b0;
  logic        s_a_ready, s_b_ready, s_sel, s_out_valid, s_out_src;
  logic [7:0]  s_out_data;
  logic [1:0]  s_cnt_a, s_cnt_b;

  int errors = 0;
  int checks = 0;

  logic [8:0]  sb[$];
  logic        m_valid, m_prio;
  logic [15:0] m_cnt_a, m_cnt_b;

  always #5 clk = ~clk;

  rr_arb2 #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .out_src(out_src),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  rr_arb2 #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .a_valid(s_valid), .a_data(8'h5A), .a_ready(s_a_ready),
    .b_valid(1'b0), .b_data(8'h00), .b_ready(s_b_ready),
    .sel(s_sel), .out_valid(s_out_valid), .out_data(s_out_data),
    .out_ready(1'b1), .out_src(s_out_src),
    .cnt_a(s_cnt_a), .cnt_b(s_cnt_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_prio  = 1'b0;
    m_cnt_a = 16'd0;
    m_cnt_b = 16'd0;
    sb.delete();
  endtask

  // Called 1 time unit after a rising edge; returns at the same point of the next cycle.
  task automatic do_reset();
    a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic step(input logic av, input logic [7:0] ad, input logic bv,
                      input logic [7:0] bd, input logic ordy);
    logic       ld, any, g;
    logic [8:0] e;
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
    @(negedge clk);
    ld  = !m_valid || ordy;
    any = av || bv;
    if (av && bv)  g = m_prio;
    else if (bv)   g = 1'b1;
    else if (av)   g = 1'b0;
    else           g = m_prio;
    check("sel", sel, g);
    check("a_ready", a_ready, ld && any && !g);
    check("b_ready", b_ready, ld && any && g);
    check("out_valid", out_valid, m_valid);
    check("cnt_a", cnt_a, m_cnt_a);
    check("cnt_b", cnt_b, m_cnt_b);
    if (m_valid) begin
      if (sb.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb[0];
        check("out_data", out_data, e[7:0]);
        check("out_src", out_src, e[8]);
        if (ordy) void'(sb.pop_front());
      end
    end
    if (ld) begin
      if (any) begin
        sb.push_back({g, g ? bd : ad});
        m_valid = 1'b1;
        m_prio  = !g;
        if (g) begin
          if (m_cnt_b != 16'hFFFF) m_cnt_b = m_cnt_b + 16'd1;
        end else begin
          if (m_cnt_a != 16'hFFFF) m_cnt_a = m_cnt_a + 16'd1;
        end
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    model_reset();
    #2;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_sel", sel, 1'b0);
    check("rst_cnt_a", cnt_a, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Alternation: both valid, downstream always ready.
    for (int i = 0; i < 6; i++) step(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    check("alt_cnt_a", cnt_a, 16'd3);
    check("alt_cnt_b", cnt_b, 16'd3);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check("alt_drained", out_valid, 1'b0);

    // Single requester B, then both: A must win next.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 8'h30 + 8'(i), 1'b1);
    check("single_cnt_b", cnt_b, 16'd4);
    a_valid = 1'b1; a_data = 8'h11; b_valid = 1'b1; b_data = 8'h22; out_ready = 1'b1;
    #1;
    check("single_next_a", a_ready, 1'b1);
    step(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Back-pressure: stall three cycles after the first load.
    do_reset();
    step(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
    check("bp_hold", out_data, 8'h11);
    step(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    check("bp_next", out_data, 8'h22);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    check("bp_cnt_b", cnt_b, 16'd1);

    // Simultaneous drain and load with only A requesting.
    do_reset();
    step(1'b1, 8'hA0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hA1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 8'hA2, 1'b0, 8'h00, 1'b1);
    check("dl_no_bubble", out_data, 8'hA2);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Mid-cycle reset with a held word, then idle.
    do_reset();
    step(1'b1, 8'h77, 1'b0, 8'h00, 1'b0);
    a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_data", out_data, 8'h00);
    check("mid_rst_cnt_a", cnt_a, 16'd0);
    check("mid_rst_sel", sel, 1'b0);
    check("mid_rst_a_ready", a_ready, 1'b0);
    check("mid_rst_b_ready", b_ready, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

    // Saturation on the 2-bit counter instance.
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check("sat_cnt_a", s_cnt_a, 2'd3);
    check("sat_cnt_b", s_cnt_b, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
